// File: rtl/rf_write_arbiter_pkg.sv
// Shared register-file constants: data/select widths, GPR count and arbiter FSM states.
package rf_write_arbiter_pkg;
  localparam int DWIDTH_DAT    = 16;
  localparam int AWIDTH_REG    = 3;
  localparam int INST_START    = 0;
  localparam int RF_NREG       = 6;
  localparam int RF_STARVE_MAX = 4;

  localparam logic [0:0] ARB_IDLE  = 1'b0;
  localparam logic [0:0] ARB_CLEAR = 1'b1;
endpackage

// File: rtl/rf_write_arbiter.sv
// Purpose: owns the RF write port; arbitrates CPU writeback, debug host and a GPR clear sequencer.
// Latency: zero -- the write is muxed combinationally in the request cycle (keeps RF forwarding intact).
// Backpressure: CPU is stalled when not granted; debug is held until dbg_ack and is forced after STARVE_MAX denials.
module rf_write_arbiter
  import rf_write_arbiter_pkg::*;
#(
  parameter int DWIDTH     = DWIDTH_DAT,
  parameter int AWIDTH     = AWIDTH_REG,
  parameter int NREG       = RF_NREG,
  parameter int STARVE_MAX = RF_STARVE_MAX
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_we,
  input  logic [AWIDTH-1:0] cpu_ws,
  input  logic [DWIDTH-1:0] cpu_wd,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic [AWIDTH-1:0] dbg_ws,
  input  logic [DWIDTH-1:0] dbg_wd,
  output logic              dbg_ack,
  output logic              dbg_err,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              clr_done,
  output logic [AWIDTH-1:0] rf_ws,
  output logic [DWIDTH-1:0] rf_wd,
  output logic              rf_we
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [AWIDTH-1:0] NREG_A     = AWIDTH'(NREG);
  localparam logic [AWIDTH-1:0] LAST_IDX   = AWIDTH'(NREG - 1);
  localparam logic [SW-1:0]     STARVE_LIM = SW'(STARVE_MAX);

  logic [0:0]        fsm;
  logic [AWIDTH-1:0] clr_idx;
  logic [SW-1:0]     starve_cnt;
  logic [SW-1:0]     starve_nxt;
  logic              dbg_sel;
  logic              dbg_ok;
  logic              cpu_ok;

  // Debug wins when the CPU is idle, or when it has been passed over STARVE_MAX times.
  assign dbg_sel = dbg_req && ((starve_cnt == STARVE_LIM) || !cpu_we);
  assign dbg_ok  = (dbg_ws < NREG_A);
  assign cpu_ok  = (cpu_ws < NREG_A);

  always_comb begin
    rf_ws      = cpu_ws;
    rf_wd      = cpu_wd;
    rf_we      = 1'b0;
    cpu_stall  = cpu_we;
    dbg_ack    = 1'b0;
    dbg_err    = 1'b0;
    clr_busy   = 1'b0;
    clr_done   = 1'b0;
    starve_nxt = starve_cnt;
    if (rst) begin
      starve_nxt = '0;
    end else if (fsm == ARB_CLEAR) begin
      rf_ws    = clr_idx;
      rf_wd    = '0;
      rf_we    = 1'b1;
      clr_busy = 1'b1;
      clr_done = (clr_idx == LAST_IDX);
    end else if (dbg_sel) begin
      rf_ws      = dbg_ws;
      rf_wd      = dbg_wd;
      rf_we      = dbg_ok;
      dbg_ack    = 1'b1;
      dbg_err    = !dbg_ok;
      starve_nxt = '0;
    end else if (cpu_we) begin
      rf_we      = cpu_ok;
      cpu_stall  = 1'b0;
      if (!dbg_req)
        starve_nxt = '0;
      else if (starve_cnt != STARVE_LIM)
        starve_nxt = starve_cnt + SW'(1);
    end else begin
      starve_nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm        <= ARB_IDLE;
      clr_idx    <= '0;
      starve_cnt <= '0;
    end else begin
      starve_cnt <= starve_nxt;
      if (fsm == ARB_IDLE) begin
        if (clr_start) begin
          fsm     <= ARB_CLEAR;
          clr_idx <= '0;
        end
      end else if (clr_idx == LAST_IDX) begin
        fsm     <= ARB_IDLE;
        clr_idx <= '0;
      end else begin
        clr_idx <= clr_idx + AWIDTH'(1);
      end
    end
  end
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Randomized + directed bench for rf_write_arbiter against a behavioural arbitration/RF model.
module tb_rf_write_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_we;
  logic [2:0]  cpu_ws;
  logic [15:0] cpu_wd;
  logic        cpu_stall;
  logic        dbg_req;
  logic [2:0]  dbg_ws;
  logic [15:0] dbg_wd;
  logic        dbg_ack;
  logic        dbg_err;
  logic        clr_start;
  logic        clr_busy;
  logic        clr_done;
  logic [2:0]  rf_ws;
  logic [15:0] rf_wd;
  logic        rf_we;

  int errors = 0;
  int checks = 0;

  rf_write_arbiter dut (
    .clk(clk), .rst(rst),
    .cpu_we(cpu_we), .cpu_ws(cpu_ws), .cpu_wd(cpu_wd), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_ws(dbg_ws), .dbg_wd(dbg_wd), .dbg_ack(dbg_ack), .dbg_err(dbg_err),
    .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
    .rf_ws(rf_ws), .rf_wd(rf_wd), .rf_we(rf_we)
  );

  always #5 clk = ~clk;

  // Register file driven by the DUT's write port (index 6 = PC, 7 unused).
  logic [15:0] rf_mem [0:7] = '{default: 16'h0};
  always @(posedge clk) if (rf_we) rf_mem[rf_ws] <= rf_wd;

  // Reference model state
  logic [15:0] m_rf [0:7] = '{default: 16'h0};
  int m_denied     = 0;  // consecutive cycles debug waited behind the CPU
  int m_clear_left = 0;  // remaining clear writes, 0 = idle
  int m_clear_pos  = 0;
  logic m_ack;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic cycle();
    logic e_we, e_stall, e_ack, e_err, e_busy, e_done;
    logic [2:0] e_ws;
    logic [15:0] e_wd;
    bit force_dbg;
    e_we = 0; e_stall = cpu_we; e_ack = 0; e_err = 0; e_busy = 0; e_done = 0;
    e_ws = cpu_ws; e_wd = cpu_wd;
    if (rst) begin
    end else if (m_clear_left > 0) begin
      e_we = 1; e_ws = 3'(m_clear_pos); e_wd = 16'h0; e_busy = 1;
      e_done = (m_clear_left == 1);
    end else begin
      force_dbg = dbg_req && (m_denied >= 4);
      if (force_dbg || (dbg_req && !cpu_we)) begin
        e_ack = 1; e_err = (dbg_ws >= 6); e_we = (dbg_ws < 6);
        e_ws = dbg_ws; e_wd = dbg_wd;
      end else if (cpu_we) begin
        e_stall = 0; e_we = (cpu_ws < 6);
      end
    end
    @(negedge clk);
    chk("rf_we", 32'(rf_we), 32'(e_we));
    chk("cpu_stall", 32'(cpu_stall), 32'(e_stall));
    chk("dbg_ack", 32'(dbg_ack), 32'(e_ack));
    chk("dbg_err", 32'(dbg_err), 32'(e_err));
    chk("clr_busy", 32'(clr_busy), 32'(e_busy));
    chk("clr_done", 32'(clr_done), 32'(e_done));
    if (e_we) begin
      chk("rf_ws", 32'(rf_ws), 32'(e_ws));
      chk("rf_wd", 32'(rf_wd), 32'(e_wd));
    end
    @(posedge clk);
    if (e_we) m_rf[e_ws] = e_wd;
    m_ack = e_ack;
    if (rst) begin
      m_denied = 0; m_clear_left = 0; m_clear_pos = 0;
    end else if (m_clear_left > 0) begin
      m_clear_left--; m_clear_pos++;
    end else begin
      if (cpu_we && dbg_req && !e_ack) m_denied = (m_denied < 4) ? m_denied + 1 : 4;
      else m_denied = 0;
      if (clr_start) begin m_clear_left = 6; m_clear_pos = 0; end
    end
    #1;
  endtask

  task automatic chk_rf(input string tag);
    for (int i = 0; i < 8; i++) chk(tag, 32'(rf_mem[i]), 32'(m_rf[i]));
  endtask

  task automatic preload_ffff();
    cpu_we = 1; cpu_wd = 16'hFFFF;
    for (int i = 0; i < 6; i++) begin cpu_ws = 3'(i); cycle(); end
    cpu_we = 0;
  endtask

  initial begin
    int n;
    rst = 1; cpu_we = 0; cpu_ws = 0; cpu_wd = 0;
    dbg_req = 0; dbg_ws = 0; dbg_wd = 0; clr_start = 0;
    @(posedge clk); #1;
    cpu_we = 1; cpu_ws = 3; dbg_req = 1; clr_start = 1;
    cycle(); cycle();
    rst = 0; dbg_req = 0; clr_start = 0;

    // Simple CPU write
    cpu_we = 1; cpu_ws = 2; cpu_wd = 16'h00AB;
    cycle();
    chk("r2_after_cpu", 32'(rf_mem[2]), 32'h00AB);

    // Starvation: CPU every cycle, debug forced on cycle 5
    cpu_ws = 1; cpu_wd = 16'h5555;
    dbg_req = 1; dbg_ws = 3; dbg_wd = 16'h1234;
    n = 0;
    while (dbg_req && n < 20) begin
      cycle(); n++;
      if (m_ack) dbg_req = 0;
    end
    chk("starve_ack_cycle", 32'(n), 32'd5);
    chk("r3_after_force", 32'(rf_mem[3]), 32'h1234);
    cycle();

    // Debug write to PC address is rejected
    cpu_we = 0; dbg_req = 1; dbg_ws = 6; dbg_wd = 16'hBEEF;
    cycle();
    dbg_req = 0;
    chk("pc_untouched", 32'(rf_mem[6]), 32'h0);

    // Full clear with CPU held
    preload_ffff();
    clr_start = 1; cpu_we = 1; cpu_ws = 7; cpu_wd = 16'h0;
    cycle();
    clr_start = 0; cpu_ws = 1; cpu_wd = 16'h7777;
    for (int i = 0; i < 6; i++) cycle();
    cpu_we = 0;
    for (int i = 0; i < 6; i++) chk("cleared", 32'(rf_mem[i]), 32'h0);

    // Reset on the third clear cycle
    preload_ffff();
    clr_start = 1; cycle(); clr_start = 0;
    cycle(); cycle();
    rst = 1; cycle(); rst = 0;
    cycle();
    for (int i = 3; i < 6; i++) chk("kept_ffff", 32'(rf_mem[i]), 32'hFFFF);
    chk("r0_cleared", 32'(rf_mem[0]), 32'h0);

    // Level clr_start: back-to-back sequences, debug waits for the gap
    clr_start = 1; cycle();
    dbg_req = 1; dbg_ws = 4; dbg_wd = 16'h4444;
    n = 0;
    while (dbg_req && n < 20) begin
      cycle(); n++;
      if (m_ack) dbg_req = 0;
    end
    chk("ack_in_gap", 32'(n), 32'd7);
    for (int i = 0; i < 6; i++) cycle();
    clr_start = 0;
    cycle();
    chk_rf("rf_directed");

    // Randomized traffic
    for (int c = 0; c < 800; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      cpu_we = $urandom_range(0, 2) != 0;
      cpu_ws = 3'($urandom_range(0, 7));
      cpu_wd = 16'($urandom);
      if (!dbg_req && $urandom_range(0, 2) == 0) begin
        dbg_req = 1;
        dbg_ws = 3'($urandom_range(0, 7));
        dbg_wd = 16'($urandom);
      end
      clr_start = ($urandom_range(0, 39) == 0);
      cycle();
      if (m_ack) dbg_req = 0;
    end
    rst = 0; cpu_we = 0; dbg_req = 0; clr_start = 0;
    cycle();
    chk_rf("rf_random");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
